// File: rtl/approx_max_pipe_if.sv
// Operand/result handshake bundle for approx_max_pipe.
// slave is the block itself; master is the producer/consumer side.
interface approx_max_pipe_if #(
    parameter int WIDTH = 4
);
    logic             approx_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic             out_sel;
    logic             out_frame_done;
    logic [WIDTH-1:0] out_frame_max;

    modport master (
        output approx_en, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_max, out_sel, out_frame_done, out_frame_max
    );

    modport slave (
        input  approx_en, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_max, out_sel, out_frame_done, out_frame_max
    );
endinterface

// File: rtl/approx_max_pipe.sv
// Two-stage pipelined max(A,B) with optional LSB-dropping approximation
// and a running max over fixed-length frames of output results.
module approx_max_pipe #(
    parameter int WIDTH     = 4,
    parameter int DROP_BITS = 1,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input logic              clk,
    input logic              rst_n,
    approx_max_pipe_if.slave bus
);
    // Ones above the dropped LSBs; masked full-width compare == upper-bit compare.
    localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << DROP_BITS;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             approx;
        logic             sel;
    } s1_t;

    logic [2:1]       vld_pipe;
    logic             s1_adv, s2_adv;
    s1_t              s1, s1_new;
    logic [WIDTH-1:0] max_new, fmax_next;
    logic [WIDTH-1:0] max_q, fmax_q, acc;
    logic             sel_q, done_q, done_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    assign s2_adv       = !vld_pipe[2] || bus.out_ready;
    assign s1_adv       = !vld_pipe[1] || s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid      = vld_pipe[2];
    assign bus.out_max        = max_q;
    assign bus.out_sel        = sel_q;
    assign bus.out_frame_done = done_q;
    assign bus.out_frame_max  = fmax_q;

    // Strict greater-than so a tie keeps A.
    always_comb begin
        s1_new.a      = bus.in_a;
        s1_new.b      = bus.in_b;
        s1_new.approx = bus.approx_en;
        if (bus.approx_en) s1_new.sel = (bus.in_b & KEEP) > (bus.in_a & KEEP);
        else               s1_new.sel = bus.in_b > bus.in_a;
    end

    always_comb begin
        max_new = s1.sel ? s1.b : s1.a;
        if (s1.approx) max_new = max_new & KEEP;
        fmax_next = (max_new > acc) ? max_new : acc;
        cnt_next  = cnt + CNT_W'(1);
        done_next = (cnt_next == CNT_W'(FRAME_LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1       <= '0;
            max_q    <= '0;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            fmax_q   <= '0;
            cnt      <= '0;
            acc      <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= bus.in_valid;
                if (bus.in_valid) s1 <= s1_new;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    max_q  <= max_new;
                    sel_q  <= s1.sel;
                    fmax_q <= fmax_next;
                    done_q <= done_next;
                    // Last result of a frame still reports the frame max, then the frame restarts.
                    if (done_next) begin
                        cnt <= '0;
                        acc <= '0;
                    end else begin
                        cnt <= cnt_next;
                        acc <= fmax_next;
                    end
                end
            end
        end
    end
endmodule
